// File: rtl/pad_bus_arbiter.sv
// pad_bus_arbiter
//   Shares one tristate pad bus among N requesters. Ownership is granted
//   round-robin and one requester can keep it for at most MAXHOLD cycles
//   while others wait. Between owners the bus idles for TURN cycles in the
//   turnaround state plus one cycle in idle, so two pad drivers never
//   overlap.
//
// Optional feature macro: PAD_BUS_ARBITER_LOCK_EN
//   When defined, adds lock_i. While the owner holds lock_i high, MAXHOLD
//   preemption is suppressed and the hold count parks at MAXHOLD. In that
//   case the grant is released only when the owner drops its request.
//
// Ports
//   clk_i   clock; all state changes on the rising edge
//   rst_i   synchronous active-high reset
//   req_i   per-requester bus request (level)
//   lock_i  owner lock (only with PAD_BUS_ARBITER_LOCK_EN)
//   gnt_o   one-hot registered grant; zero when the bus has no owner
//   oe_o    registered pad drive enable, always equal to |gnt_o
//   sel_o   index of the current or most recent owner (data mux select)
//   busy_o  high in the grant and turnaround states
module pad_bus_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned TURN    = 1,
  parameter int unsigned MAXHOLD = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_i,
`ifdef PAD_BUS_ARBITER_LOCK_EN
  input  logic                 lock_i,
`endif
  output logic [N-1:0]         gnt_o,
  output logic                 oe_o,
  output logic [$clog2(N)-1:0] sel_o,
  output logic                 busy_o
);

  localparam int unsigned SelW = $clog2(N);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StTurn  = 2'd2;

  localparam logic [7:0]      HoldMax = 8'(MAXHOLD);
  localparam logic [2:0]      TurnLen = 3'(TURN);
  localparam logic [SelW-1:0] LastIdx = SelW'(N - 1);

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            oe_q, oe_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic [7:0]      hc_q, hc_d;
  logic [2:0]      tc_q, tc_d;

  logic lock;
`ifdef PAD_BUS_ARBITER_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  // Round-robin winner: lowest requester at or above ptr_q, otherwise the
  // lowest requester overall (the wrap-around case). Each downward loop
  // leaves the lowest qualifying index in win.
  logic [SelW-1:0] win;
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) win = SelW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i] && (SelW'(i) >= ptr_q)) win = SelW'(i);
    end
  end

  logic owner_req;
  logic rivals;
  logic at_max;
  logic release_now;

  assign owner_req   = |(req_i & gnt_q);
  assign rivals      = |(req_i & ~gnt_q);
  assign at_max      = (hc_q == HoldMax);
  // A dropped request and a MAXHOLD expiry in the same cycle are one release.
  assign release_now = ~owner_req | (at_max & rivals & ~lock);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hc_d    = hc_q;
    tc_d    = tc_q;

    case (state_q)
      StIdle: begin
        if (|req_i) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          sel_d      = win;
          hc_d       = 8'd1;
          state_d    = StGrant;
        end
      end

      StGrant: begin
        if (release_now) begin
          gnt_d   = '0;
          ptr_d   = (sel_q == LastIdx) ? '0 : sel_q + SelW'(1);
          tc_d    = TurnLen;
          state_d = StTurn;
        end else if (at_max) begin
          // No competitor (or locked): keep the grant. Lock parks the count.
          hc_d = lock ? HoldMax : 8'd1;
        end else if (hc_q != 8'hFF) begin
          hc_d = hc_q + 8'd1;
        end
      end

      StTurn: begin
        // Requests are ignored here; arbitration resumes in idle.
        tc_d = tc_q - 3'd1;
        if (tc_q <= 3'd1) state_d = StIdle;
      end

      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    oe_d = |gnt_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      oe_q    <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hc_q    <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hc_q    <= hc_d;
      tc_q    <= tc_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign oe_o   = oe_q;
  assign sel_o  = sel_q;
  assign busy_o = (state_q != StIdle);

endmodule
